// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS main controller: opcodes, ALUOp codes,
// datapath mux codes and the controller state enumeration.
package multicycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Same values the downstream ALU control decoder expects.
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_ADDI  = 3'b011;
    localparam logic [2:0] ALUOP_ANDI  = 3'b100;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTYPE  = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDI   = 4'd9,
        S_ANDI   = 4'd10,
        S_IWB    = 4'd11,
        S_JUMP   = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

endpackage

// File: rtl/multicycle_next_state.sv
// Pure combinational next-state function of the multicycle controller:
// (current state, opcode from the IR, memory ready) -> next state.
module multicycle_next_state
    import multicycle_control_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [3:0]     state_i,
    input  logic [OPW-1:0] opcode_i,
    input  logic           mem_ready_i,
    output logic [3:0]     next_state_o
);

    state_t cur;
    state_t nxt;

    assign cur          = state_t'(state_i);
    assign next_state_o = nxt;

    always_comb begin
        // NOTE: every variable written here gets a value before the case so no latch is inferred.
        nxt = S_FETCH;
        unique case (cur)
            S_FETCH:  nxt = mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (opcode_i)
                    OP_LW, OP_SW:   nxt = S_MEMADR;
                    OP_RTYPE:       nxt = S_RTYPE;
                    OP_BEQ, OP_BNE: nxt = S_BRANCH;
                    OP_ADDI:        nxt = S_ADDI;
                    OP_ANDI:        nxt = S_ANDI;
                    OP_J:           nxt = S_JUMP;
                    default:        nxt = S_TRAP;
                endcase
            end
            // Only lw/sw reach MEMADR; anything but sw is treated as a load.
            S_MEMADR: nxt = (opcode_i == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  nxt = mem_ready_i ? S_MEMWB : S_MEMRD;
            S_MEMWB:  nxt = S_FETCH;
            S_MEMWR:  nxt = mem_ready_i ? S_FETCH : S_MEMWR;
            S_RTYPE:  nxt = S_RWB;
            S_RWB:    nxt = S_FETCH;
            S_BRANCH: nxt = S_FETCH;
            S_ADDI:   nxt = S_IWB;
            S_ANDI:   nxt = S_IWB;
            S_IWB:    nxt = S_FETCH;
            S_JUMP:   nxt = S_FETCH;
            S_TRAP:   nxt = S_TRAP;
            default:  nxt = S_FETCH;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: state register plus
// output decode; reset forces every output low in the same cycle.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int OPW  = 6,
    parameter int AOPW = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OPW-1:0]  opcode,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic            pc_write_beq,
    output logic            pc_write_bne,
    output logic            i_or_d,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic            mem_to_reg,
    output logic            reg_dst,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [AOPW-1:0] alu_op,
    output logic [1:0]      pc_source,
    output logic            illegal,
    output logic [3:0]      state
);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] next_state;

    multicycle_next_state #(
        .OPW (OPW)
    ) u_next_state (
        .state_i      (state_q),
        .opcode_i     (opcode),
        .mem_ready_i  (mem_ready),
        .next_state_o (next_state)
    );

    assign state_d = state_t'(next_state);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        pc_write     = 1'b0;
        pc_write_beq = 1'b0;
        pc_write_bne = 1'b0;
        i_or_d       = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        mem_to_reg   = 1'b0;
        reg_dst      = 1'b0;
        reg_write    = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = SRCB_B;
        alu_op       = ALUOP_ADD;
        pc_source    = PCSRC_ALU;
        illegal      = 1'b0;
        state        = 4'd0;

        if (!reset) begin
            state = state_q;
            unique case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    // IR and PC only load on the cycle the instruction word arrives.
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: alu_src_b = SRCB_IMM_SH2;
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_RTYPE: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_RTYPE;
                end
                S_RWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a    = 1'b1;
                    alu_op       = ALUOP_SUB;
                    pc_source    = PCSRC_ALUOUT;
                    pc_write_beq = (opcode == OP_BEQ);
                    pc_write_bne = (opcode == OP_BNE);
                end
                S_ADDI: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALUOP_ADDI;
                end
                S_ANDI: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALUOP_ANDI;
                end
                S_IWB:   reg_write = 1'b1;
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = PCSRC_JUMP;
                end
                S_TRAP:  illegal = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control: one record per clock
// cycle with hand-computed expected state and control word.
module tb_multicycle_control;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_beq;
        logic       pc_write_bne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctl_t;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       rdy;
        logic [3:0] st;
        ctl_t       ctl;
    } vec_t;

    localparam logic [5:0] R    = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] ANDI = 6'b001100;
    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;

    localparam ctl_t C_ZERO       = '0;
    localparam ctl_t C_FETCH_WAIT = '{mem_read: 1'b1, alu_src_b: 2'b01, default: '0};
    localparam ctl_t C_FETCH_RDY  = '{mem_read: 1'b1, alu_src_b: 2'b01, ir_write: 1'b1, pc_write: 1'b1, default: '0};
    localparam ctl_t C_DECODE     = '{alu_src_b: 2'b11, default: '0};
    localparam ctl_t C_MEMADR     = '{alu_src_a: 1'b1, alu_src_b: 2'b10, default: '0};
    localparam ctl_t C_MEMRD      = '{mem_read: 1'b1, i_or_d: 1'b1, default: '0};
    localparam ctl_t C_MEMWB      = '{reg_write: 1'b1, mem_to_reg: 1'b1, default: '0};
    localparam ctl_t C_MEMWR      = '{mem_write: 1'b1, i_or_d: 1'b1, default: '0};
    localparam ctl_t C_RTYPE      = '{alu_src_a: 1'b1, alu_op: 3'b010, default: '0};
    localparam ctl_t C_RWB        = '{reg_write: 1'b1, reg_dst: 1'b1, default: '0};
    localparam ctl_t C_BEQ        = '{alu_src_a: 1'b1, alu_op: 3'b001, pc_source: 2'b01, pc_write_beq: 1'b1, default: '0};
    localparam ctl_t C_BNE        = '{alu_src_a: 1'b1, alu_op: 3'b001, pc_source: 2'b01, pc_write_bne: 1'b1, default: '0};
    localparam ctl_t C_ADDI       = '{alu_src_a: 1'b1, alu_src_b: 2'b10, alu_op: 3'b011, default: '0};
    localparam ctl_t C_ANDI       = '{alu_src_a: 1'b1, alu_src_b: 2'b10, alu_op: 3'b100, default: '0};
    localparam ctl_t C_IWB        = '{reg_write: 1'b1, default: '0};
    localparam ctl_t C_JUMP       = '{pc_write: 1'b1, pc_source: 2'b10, default: '0};
    localparam ctl_t C_TRAP       = '{illegal: 1'b1, default: '0};

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_beq, pc_write_bne, i_or_d, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state;
    ctl_t       act;

    int total = 0;
    int bad   = 0;
    int step_no = 0;
    vec_t vecs[$];

    multicycle_control #(
        .OPW  (6),
        .AOPW (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .pc_write_beq (pc_write_beq),
        .pc_write_bne (pc_write_bne),
        .i_or_d       (i_or_d),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .mem_to_reg   (mem_to_reg),
        .reg_dst      (reg_dst),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .pc_source    (pc_source),
        .illegal      (illegal),
        .state        (state)
    );

    assign act = '{pc_write: pc_write, pc_write_beq: pc_write_beq, pc_write_bne: pc_write_bne,
                   i_or_d: i_or_d, mem_read: mem_read, mem_write: mem_write, ir_write: ir_write,
                   mem_to_reg: mem_to_reg, reg_dst: reg_dst, reg_write: reg_write,
                   alu_src_a: alu_src_a, alu_src_b: alu_src_b, alu_op: alu_op,
                   pc_source: pc_source, illegal: illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic add(input logic rst, input logic [5:0] op, input logic rdy,
                       input logic [3:0] st, input ctl_t ctl);
        vec_t v;
        v.rst = rst;
        v.op  = op;
        v.rdy = rdy;
        v.st  = st;
        v.ctl = ctl;
        vecs.push_back(v);
    endtask

    // Drive one cycle's inputs after the falling edge, compare before the next rising edge.
    task automatic step(input logic rst, input logic [5:0] op, input logic rdy,
                        input logic [3:0] st, input ctl_t ctl, input string tag);
        @(negedge clk);
        reset     = rst;
        opcode    = op;
        mem_ready = rdy;
        #1;
        check($sformatf("%s#%0d state", tag, step_no), {28'd0, state}, {28'd0, st});
        check($sformatf("%s#%0d ctl", tag, step_no), {13'd0, act}, {13'd0, ctl});
        check($sformatf("%s#%0d rd_wr_excl", tag, step_no), {31'd0, mem_read & mem_write}, 32'd0);
        check($sformatf("%s#%0d pc_excl", tag, step_no),
              {31'd0, pc_write & (pc_write_beq | pc_write_bne)}, 32'd0);
        step_no++;
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = R;
        mem_ready = 1'b0;

        // Reset held two cycles, then release into a waiting fetch.
        add(1, R, 0, 4'd0, C_ZERO);
        add(1, R, 1, 4'd0, C_ZERO);
        add(0, R, 0, 4'd0, C_FETCH_WAIT);
        // R-type: 0,1,6,7,0 with mem_ready ignored in DECODE.
        add(0, R, 1, 4'd0, C_FETCH_RDY);
        add(0, R, 0, 4'd1, C_DECODE);
        add(0, R, 1, 4'd6, C_RTYPE);
        add(0, R, 1, 4'd7, C_RWB);
        // lw with three stalled MEMRD cycles.
        add(0, LW, 1, 4'd0, C_FETCH_RDY);
        add(0, LW, 1, 4'd1, C_DECODE);
        add(0, LW, 1, 4'd2, C_MEMADR);
        add(0, LW, 0, 4'd3, C_MEMRD);
        add(0, LW, 0, 4'd3, C_MEMRD);
        add(0, LW, 0, 4'd3, C_MEMRD);
        add(0, LW, 1, 4'd3, C_MEMRD);
        add(0, LW, 0, 4'd4, C_MEMWB);
        // sw completing immediately.
        add(0, SW, 1, 4'd0, C_FETCH_RDY);
        add(0, SW, 1, 4'd1, C_DECODE);
        add(0, SW, 1, 4'd2, C_MEMADR);
        add(0, SW, 1, 4'd5, C_MEMWR);
        // beq then bne.
        add(0, BEQ, 1, 4'd0, C_FETCH_RDY);
        add(0, BEQ, 1, 4'd1, C_DECODE);
        add(0, BEQ, 1, 4'd8, C_BEQ);
        add(0, BNE, 1, 4'd0, C_FETCH_RDY);
        add(0, BNE, 1, 4'd1, C_DECODE);
        add(0, BNE, 1, 4'd8, C_BNE);
        // addi, andi, j.
        add(0, ADDI, 1, 4'd0, C_FETCH_RDY);
        add(0, ADDI, 1, 4'd1, C_DECODE);
        add(0, ADDI, 0, 4'd9, C_ADDI);
        add(0, ADDI, 1, 4'd11, C_IWB);
        add(0, ANDI, 1, 4'd0, C_FETCH_RDY);
        add(0, ANDI, 1, 4'd1, C_DECODE);
        add(0, ANDI, 1, 4'd10, C_ANDI);
        add(0, ANDI, 0, 4'd11, C_IWB);
        add(0, J, 1, 4'd0, C_FETCH_RDY);
        add(0, J, 1, 4'd1, C_DECODE);
        add(0, J, 1, 4'd12, C_JUMP);
        add(0, J, 0, 4'd0, C_FETCH_WAIT);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].op, vecs[i].rdy, vecs[i].st, vecs[i].ctl, "vec");
        end

        // Reset during a stalled store: no mem_write in the reset cycle, then FETCH.
        step(0, SW, 1, 4'd0, C_FETCH_RDY, "rst_sw");
        step(0, SW, 1, 4'd1, C_DECODE, "rst_sw");
        step(0, SW, 1, 4'd2, C_MEMADR, "rst_sw");
        step(0, SW, 0, 4'd5, C_MEMWR, "rst_sw");
        step(0, SW, 0, 4'd5, C_MEMWR, "rst_sw");
        step(1, SW, 0, 4'd0, C_ZERO, "rst_sw");
        step(0, SW, 0, 4'd0, C_FETCH_WAIT, "rst_sw");

        // Reset during a stalled load.
        step(0, LW, 1, 4'd0, C_FETCH_RDY, "rst_lw");
        step(0, LW, 1, 4'd1, C_DECODE, "rst_lw");
        step(0, LW, 1, 4'd2, C_MEMADR, "rst_lw");
        step(0, LW, 0, 4'd3, C_MEMRD, "rst_lw");
        step(1, LW, 1, 4'd0, C_ZERO, "rst_lw");
        step(0, LW, 0, 4'd0, C_FETCH_WAIT, "rst_lw");

        // Unsupported opcode traps and stays trapped until reset.
        step(0, BAD, 1, 4'd0, C_FETCH_RDY, "trap");
        step(0, BAD, 1, 4'd1, C_DECODE, "trap");
        for (int k = 0; k < 10; k++) begin
            step(0, BAD, k[0], 4'd13, C_TRAP, "trap");
        end
        step(1, BAD, 1, 4'd0, C_ZERO, "trap");
        step(0, R, 1, 4'd0, C_FETCH_RDY, "trap");
        step(0, R, 1, 4'd1, C_DECODE, "trap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
